// File: rtl/seed_random_pkg.sv
// Shared types and constants for the seed_random card dealer family.
package seed_random_pkg;

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} dealer_state_e;

  typedef struct packed {
    logic [7:0] card;
    logic [2:0] deck;
  } card_pos_t;

  localparam int          CARD_COUNT_DEF = 52;
  localparam logic [15:0] LFSR_RESET     = 16'hACE1;
  // Right-shift Galois form of taps 16,14,13,11
  localparam logic [15:0] LFSR_TAPS      = 16'hB400;

  // Card/deck of the next shoe slot; card wraps to 1 and carries into deck.
  function automatic card_pos_t pos_step(input card_pos_t p, input int unsigned card_count,
                                         input int unsigned decks);
    card_pos_t r;
    r = p;
    if (p.card == 8'(card_count)) begin
      r.card = 8'd1;
      r.deck = (p.deck == 3'(decks - 1)) ? 3'd0 : p.deck + 3'd1;
    end else begin
      r.card = p.card + 8'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seed_random_2_seed_gen.sv
// Free-running seed index with its card/deck fields. Define SEED_RANDOM_LFSR_EN
// to add a Galois LFSR that makes the index skip an extra slot on random cycles.
module seed_random_2_seed_gen
  import seed_random_pkg::*;
#(
  parameter int CARD_COUNT = CARD_COUNT_DEF,
  parameter int DECKS      = 1,
  parameter int N          = CARD_COUNT * DECKS,
  parameter int CW         = $clog2(N)
) (
  input  logic          clk_dl_i,
  input  logic          rst_dl_i,
  output logic [CW-1:0] cnt,
  output card_pos_t     cnt_pos
);

  logic [CW-1:0] idx1, idx_nxt;
  card_pos_t     pos1, pos_nxt;

  assign idx1 = (cnt == CW'(N - 1)) ? '0 : cnt + CW'(1);
  assign pos1 = pos_step(cnt_pos, CARD_COUNT, DECKS);

`ifdef SEED_RANDOM_LFSR_EN
  logic [15:0]   lfsr;
  logic [CW-1:0] idx2;
  card_pos_t     pos2;

  assign idx2    = (idx1 == CW'(N - 1)) ? '0 : idx1 + CW'(1);
  assign pos2    = pos_step(pos1, CARD_COUNT, DECKS);
  assign idx_nxt = lfsr[0] ? idx2 : idx1;
  assign pos_nxt = lfsr[0] ? pos2 : pos1;

  always_ff @(posedge clk_dl_i) begin
    if (!rst_dl_i) lfsr <= LFSR_RESET;
    else           lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0);
  end
`else
  assign idx_nxt = idx1;
  assign pos_nxt = pos1;
`endif

  always_ff @(posedge clk_dl_i) begin
    if (!rst_dl_i) begin
      cnt     <= '0;
      cnt_pos <= '{card: 8'd1, deck: 3'd0};
    end else begin
      cnt     <= idx_nxt;
      cnt_pos <= pos_nxt;
    end
  end

endmodule

// File: rtl/seed_random_2_dealer.sv
// Card dealer: draws undealt shoe slots starting at a free-running seed index,
// scanning forward past dealt slots. Optional SEED_RANDOM_LFSR_EN randomizes the seed.
module seed_random_2_dealer
  import seed_random_pkg::*;
#(
  parameter int CARD_COUNT = CARD_COUNT_DEF,
  parameter int DECKS      = 1
) (
  input  logic                                    clk_dl_i,
  input  logic                                    rst_dl_i,
  input  logic                                    req_i,
  input  logic                                    ack_i,
  input  logic                                    shuffle_i,
  output logic [7:0]                              card_o,
  output logic [2:0]                              deck_o,
  output logic                                    valid_o,
  output logic [$clog2(CARD_COUNT*DECKS+1)-1:0]   remaining_o,
  output logic                                    empty_o
);

  localparam int N  = CARD_COUNT * DECKS;
  localparam int CW = $clog2(N);
  localparam int RW = $clog2(N + 1);

  dealer_state_e state_q, state_d;
  logic [CW-1:0] cnt, ptr_q, ptr_nxt;
  card_pos_t     cnt_pos, ptr_pos_q;
  logic [N-1:0]  bitmap_q;
  logic          load, hit, adv;

  seed_random_2_seed_gen #(.CARD_COUNT(CARD_COUNT), .DECKS(DECKS)) u_seed (
    .clk_dl_i(clk_dl_i),
    .rst_dl_i(rst_dl_i),
    .cnt     (cnt),
    .cnt_pos (cnt_pos)
  );

  assign empty_o = (remaining_o == '0);
  assign ptr_nxt = (ptr_q == CW'(N - 1)) ? '0 : ptr_q + CW'(1);

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    hit     = 1'b0;
    adv     = 1'b0;
    if (shuffle_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (req_i && !empty_o) begin
          load    = 1'b1;
          state_d = SEARCH;
        end
        SEARCH: if (!bitmap_q[ptr_q]) begin
          hit     = 1'b1;
          state_d = DONE;
        end else begin
          adv = 1'b1;
        end
        DONE: if (ack_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_dl_i) begin
    if (!rst_dl_i) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      ptr_pos_q   <= '{card: 8'd1, deck: 3'd0};
      bitmap_q    <= '0;
      remaining_o <= RW'(N);
      card_o      <= '0;
      deck_o      <= '0;
      valid_o     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (shuffle_i) begin
        // Card fields intentionally hold their last value across a shuffle
        bitmap_q    <= '0;
        remaining_o <= RW'(N);
        valid_o     <= 1'b0;
      end else begin
        if (load) begin
          ptr_q     <= cnt;
          ptr_pos_q <= cnt_pos;
        end
        if (adv) begin
          ptr_q     <= ptr_nxt;
          ptr_pos_q <= pos_step(ptr_pos_q, CARD_COUNT, DECKS);
        end
        if (hit) begin
          bitmap_q[ptr_q] <= 1'b1;
          card_o          <= ptr_pos_q.card;
          deck_o          <= ptr_pos_q.deck;
          remaining_o     <= remaining_o - RW'(1);
          valid_o         <= 1'b1;
        end
        if (state_q == DONE && ack_i) valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seed_random_2_dealer.sv
// Bench for seed_random_2_dealer: DECKS=1 and DECKS=2 instances checked every cycle
// against a slot-level shoe model, plus directed draws with hand-computed results.
module tb_seed_random_2_dealer;

  localparam int CC = 52;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rstn, req, ack, shf;
  logic [7:0] card0, card1;
  logic [2:0] deck0, deck1;
  logic       valid0, valid1, empty0, empty1;
  logic [5:0] rem0;
  logic [6:0] rem1;

  seed_random_2_dealer #(.CARD_COUNT(CC), .DECKS(1)) dut0 (
    .clk_dl_i(clk), .rst_dl_i(rstn[0]), .req_i(req[0]), .ack_i(ack[0]), .shuffle_i(shf[0]),
    .card_o(card0), .deck_o(deck0), .valid_o(valid0), .remaining_o(rem0), .empty_o(empty0));

  seed_random_2_dealer #(.CARD_COUNT(CC), .DECKS(2)) dut1 (
    .clk_dl_i(clk), .rst_dl_i(rstn[1]), .req_i(req[1]), .ack_i(ack[1]), .shuffle_i(shf[1]),
    .card_o(card1), .deck_o(deck1), .valid_o(valid1), .remaining_o(rem1), .empty_o(empty1));

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 0;

  task automatic check(input string nm, input int i, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s inst%0d: got %0d expected %0d at %0t", nm, i, act, exp, $time);
  endtask

  function automatic int nsz(input int i);
    return (i == 0) ? CC : 2 * CC;
  endfunction

  function automatic void outs(input int i, output int c, output int d, output int v,
                               output int r, output int e);
    if (i == 0) begin c = card0; d = deck0; v = valid0; r = rem0; e = empty0; end
    else        begin c = card1; d = deck1; v = valid1; r = rem1; e = empty1; end
  endfunction

  function automatic bit vld(input int i);
    return (i == 0) ? valid0 : valid1;
  endfunction

  // Shoe model: a request picks the first undealt slot at or after the seed,
  // and the card appears after one cycle plus one cycle per skipped slot.
  int mcnt[2], mrem[2], phase[2], cd[2], mslot[2], mcard[2], mdeck[2];
  bit mvalid[2];
  bit dealt[2][256];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int n, c;
      n = nsz(i);
      if (!rstn[i]) begin
        mcnt[i] = 0; mrem[i] = n; phase[i] = 0; mcard[i] = 0; mdeck[i] = 0; mvalid[i] = 0;
        for (int s = 0; s < 256; s++) dealt[i][s] = 0;
      end else begin
        c = mcnt[i];
        mcnt[i] = (c + 1) % n;
        if (shf[i]) begin
          for (int s = 0; s < 256; s++) dealt[i][s] = 0;
          mrem[i] = n; phase[i] = 0; mvalid[i] = 0;
        end else if (phase[i] == 0) begin
          if (req[i] && mrem[i] != 0) begin
            for (int k = 0; k < n; k++) begin
              if (!dealt[i][(c + k) % n]) begin
                mslot[i] = (c + k) % n; cd[i] = k; break;
              end
            end
            phase[i] = 1;
          end
        end else if (phase[i] == 1) begin
          if (cd[i] == 0) begin
            dealt[i][mslot[i]] = 1;
            mcard[i] = mslot[i] % CC + 1;
            mdeck[i] = mslot[i] / CC;
            mrem[i]--;
            mvalid[i] = 1;
            phase[i] = 2;
          end else cd[i]--;
        end else if (ack[i]) begin
          mvalid[i] = 0; phase[i] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        int c, d, v, r, e;
        outs(i, c, d, v, r, e);
        check("valid", i, v, int'(mvalid[i]));
        check("card", i, c, mcard[i]);
        check("deck", i, d, mdeck[i]);
        check("remaining", i, r, mrem[i]);
        check("empty", i, e, int'(mrem[i] == 0));
      end
    end
  end

  task automatic wait_cnt(input int i, input int v);
    for (int k = 0; k <= nsz(i) + 2; k++) begin
      if (mcnt[i] == v) return;
      @(negedge clk);
    end
    check("seed_reach", i, mcnt[i], v);
  endtask

  // Pulses req for one edge and returns the cycle count to valid (0 = timeout).
  task automatic req_wait(input int i, output int lat);
    lat = 0;
    req[i] = 1'b1;
    for (int n = 1; n <= nsz(i) + 4; n++) begin
      @(negedge clk);
      if (n == 1) req[i] = 1'b0;
      if (vld(i)) begin lat = n; break; end
    end
    req[i] = 1'b0;
    if (lat == 0) check("draw_timeout", i, 0, 1);
  endtask

  task automatic do_ack(input int i);
    ack[i] = 1'b1;
    @(negedge clk);
    ack[i] = 1'b0;
  endtask

  task automatic do_shuffle(input int i);
    shf[i] = 1'b1;
    @(negedge clk);
    shf[i] = 1'b0;
  endtask

  task automatic draw(input int i, input int cval, input int exp_lat, input int exp_card,
                      input int exp_deck, input int exp_rem, input bit ack_it);
    int lat, c, d, v, r, e;
    wait_cnt(i, cval);
    req_wait(i, lat);
    outs(i, c, d, v, r, e);
    check("lat", i, lat, exp_lat);
    check("lit_card", i, c, exp_card);
    check("lit_deck", i, d, exp_deck);
    check("lit_rem", i, r, exp_rem);
    if (ack_it) do_ack(i);
  endtask

  initial begin
    int lat, c, d, v, r, e, held, seen_cnt, vcount;
    bit seen[64];
    rstn = 2'b00; req = '0; ack = '0; shf = '0;
    repeat (3) @(negedge clk);
    chk_en = 1;
    rstn = 2'b11;
    check("rst_valid", 0, int'(valid0), 0);
    check("rst_rem", 0, int'(rem0), 52);
    check("rst_card", 0, int'(card0), 0);
    check("rst_empty", 1, int'(empty1), 0);
    check("rst_rem", 1, int'(rem1), 104);

    // Fresh shoe, seed 5 -> card 6 two cycles after the request edge
    draw(0, 5, 2, 6, 0, 51, 1);
    do_shuffle(0);
    check("shuf_rem", 0, int'(rem0), 52);

    // Deal slots 10..12, then a seed of 10 must skip three slots to card 14
    draw(0, 10, 2, 11, 0, 51, 1);
    draw(0, 11, 2, 12, 0, 50, 1);
    draw(0, 12, 2, 13, 0, 49, 1);
    draw(0, 10, 5, 14, 0, 48, 1);

    // Two decks: slot 53 is card 2 of deck 1; dealt slot 103 wraps to slot 0
    draw(1, 53, 2, 2, 1, 103, 1);
    draw(1, 103, 2, 52, 1, 102, 1);
    draw(1, 103, 3, 1, 0, 101, 1);

    // Hold in DONE without ack, then shuffle out of it
    do_shuffle(0);
    draw(0, 20, 2, 21, 0, 51, 0);
    held = card0;
    repeat (10) begin
      @(negedge clk);
      check("hold_valid", 0, int'(valid0), 1);
      check("hold_card", 0, int'(card0), held);
    end
    do_shuffle(0);
    check("shuf_valid", 0, int'(valid0), 0);
    check("shuf_rem2", 0, int'(rem0), 52);

    // Reset in the middle of a search
    req[0] = 1'b1;
    @(negedge clk);
    req[0] = 1'b0;
    rstn[0] = 1'b0;
    @(negedge clk);
    rstn[0] = 1'b1;
    check("abort_valid", 0, int'(valid0), 0);
    check("abort_rem", 0, int'(rem0), 52);
    repeat (3) @(negedge clk);
    check("abort_nodeal", 0, int'(valid0), 0);

    // Empty the whole shoe: every card exactly once
    for (int k = 0; k < 64; k++) seen[k] = 0;
    seen_cnt = 0;
    for (int k = 0; k < 52; k++) begin
      repeat ($urandom_range(0, 7)) @(negedge clk);
      req_wait(0, lat);
      outs(0, c, d, v, r, e);
      if (v && c >= 1 && c <= 52 && !seen[c]) begin seen[c] = 1; seen_cnt++; end
      do_ack(0);
    end
    check("distinct", 0, seen_cnt, 52);
    check("empty_full", 0, int'(empty0), 1);
    req[0] = 1'b1;
    @(negedge clk);
    req[0] = 1'b0;
    vcount = 0;
    repeat (56) begin
      @(negedge clk);
      if (valid0) vcount++;
    end
    check("empty_nodeal", 0, vcount, 0);
    do_shuffle(0);

    // Random traffic; the per-cycle compare does the checking
    repeat (4000) begin
      for (int i = 0; i < 2; i++) begin
        rstn[i] = ($urandom_range(0, 399) != 0);
        shf[i]  = ($urandom_range(0, 59) == 0);
        req[i]  = ($urandom_range(0, 1) == 1);
        ack[i]  = ($urandom_range(0, 2) != 0);
      end
      @(negedge clk);
    end
    rstn = 2'b11; req = '0; ack = '0; shf = '0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seed_random_2_dealer.md
SEED_RANDOM_2_DEALER -- requirements
Module: seed_random_2_dealer

Interface
REQ-001 SHALL have parameter CARD_COUNT, default 52: distinct card values per deck, range 2..255.
REQ-002 SHALL have parameter DECKS, default 1: decks in the shoe, range 1..8; shoe size N = CARD_COUNT*DECKS.
REQ-003 SHALL have port clk_dl_i, input, 1: single clock, rising edge.
REQ-004 SHALL have port rst_dl_i, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port req_i, input, 1: draw request, sampled only in IDLE.
REQ-006 SHALL have port ack_i, input, 1: consumer accepts the presented card.
REQ-007 SHALL have port shuffle_i, input, 1: return every card to the shoe.
REQ-008 SHALL have port card_o, output, 8: card value 1..CARD_COUNT.
REQ-009 SHALL have port deck_o, output, 3: deck index 0..DECKS-1.
REQ-010 SHALL have port valid_o, output, 1: card_o/deck_o valid.
REQ-011 SHALL have port remaining_o, output, clog2(N+1): undealt card count.
REQ-012 SHALL have port empty_o, output, 1: remaining_o == 0.

Function
REQ-013 SHALL run a free-running seed index cnt in 0..N-1, advancing every cycle and wrapping N-1 -> 0, independent of FSM state.
REQ-014 SHALL keep a dealt bitmap of N bits, one per shoe slot; slot s maps to card (s mod CARD_COUNT)+1, deck s div CARD_COUNT.
REQ-015 SHALL track card and deck fields beside the scan pointer (card wraps CARD_COUNT -> 1 with deck+1; deck wraps at DECKS), with no divider.
REQ-016 SHALL use FSM states IDLE, SEARCH, DONE.
REQ-017 IDLE: req_i=1 and empty_o=0 at edge T SHALL load ptr <= cnt and enter SEARCH; req_i with empty_o=1 SHALL be ignored.
REQ-018 SEARCH: each cycle SHALL test bitmap[ptr]; if clear, set it, register card_o/deck_o, decrement remaining_o, enter DONE; if set, advance ptr with wrap N-1 -> 0.
REQ-019 On a fresh shoe, valid_o SHALL rise at T+2; each skipped dealt slot adds one cycle; worst case T+N+1.
REQ-020 DONE: valid_o=1, card_o/deck_o stable until ack_i=1; then the next edge SHALL return to IDLE with valid_o=0.
REQ-021 A draw SHALL never return a slot already dealt since the last shuffle or reset.
REQ-022 shuffle_i=1 SHALL take effect in any state: clear bitmap, remaining_o <= N, FSM <= IDLE, valid_o <= 0; card_o/deck_o hold.
REQ-023 shuffle_i and req_i in the same IDLE cycle: shuffle wins and the request is dropped.
REQ-024 ack_i outside DONE SHALL be ignored.
REQ-025 empty_o SHALL be combinational from remaining_o.

Reset
REQ-026 rst_dl_i=0 at an edge SHALL set: FSM=IDLE, cnt=0, ptr=0, bitmap clear, remaining_o=N, card_o=0, deck_o=0, valid_o=0, empty_o=0.
REQ-027 Reset SHALL abort a SEARCH or DONE transaction with no card delivered, and SHALL override shuffle_i, req_i and ack_i.

Configuration
REQ-028 With macro SEED_RANDOM_LFSR_EN defined, a 16-bit Galois LFSR (taps 16,14,13,11; reset 16'hACE1) SHALL step every cycle, and cnt SHALL advance by 1+lfsr[0] modulo N.
REQ-029 With SEED_RANDOM_LFSR_EN undefined, cnt SHALL advance by exactly 1 per cycle, and the module SHALL contain no LFSR logic.

Structure
REQ-030 The shared package seed_random_pkg SHALL hold the FSM state typedef, the default CARD_COUNT constant and the LFSR reset value and tap constants.
REQ-031 The seed index (cnt plus the optional LFSR) SHALL be the sub-module seed_random_2_seed_gen; the bitmap and FSM SHALL stay in the top.

Verification
REQ-032 Reset, then req_i pulse at T with cnt=5 (LFSR off) -> valid_o=1 at T+2, card_o=6, deck_o=0, remaining_o=51.
REQ-033 Draw 52 times with ack, DECKS=1 -> 52 distinct card_o values 1..52; then empty_o=1 and a further req_i produces no valid_o.
REQ-034 Slots 10..12 dealt, request with cnt=10 -> card_o=14 at T+5.
REQ-035 DECKS=2, request with cnt=53 -> card_o=2, deck_o=1; cnt=103 with slot 103 dealt -> ptr wraps and card_o=1, deck_o=0.
REQ-036 In DONE, hold ack_i=0 for 10 cycles -> valid_o and card_o stable; shuffle_i=1 then -> valid_o=0, remaining_o=52.
REQ-037 rst_dl_i=0 during SEARCH -> next cycle IDLE, valid_o=0, remaining_o=N; with the macro defined, LFSR=16'hACE1.
